// File: rtl/cache_wb_pkg.sv
// Shared constants and types for the cache write-back buffer.
//   LINE_AW  line-address width
//   WORD_W   Mem word width
//   WORDS    words per line (fixed at 4, beat counter is 2 bits)
//   wb_state_e  drain FSM states
//   wb_line_t   one buffered line {addr, data}
package cache_wb_pkg;

    localparam int unsigned LINE_AW = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned LINE_W  = WORDS * WORD_W;
    localparam int unsigned WADDR_W = LINE_AW + 2;

    typedef enum logic {
        IDLE,
        WRITE
    } wb_state_e;

    typedef struct packed {
        logic [LINE_AW-1:0] addr;
        logic [LINE_W-1:0]  data;
    } wb_line_t;

    // Word 'beat' of a line; word i occupies bits [32i+31:32i].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] data,
                                                    input logic [1:0]        beat);
        return data[beat*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_writeback_buffer_if.sv
// Bundle of the write-back buffer's push, Mem write and lookup signals.
//   push side : push, push_addr, push_data -> full, empty
//   Mem side  : mem_busy -> CS, RW, waddr, wdata
//   lookup    : lookup_addr -> lookup_match (+ lookup_data when WB_FORWARD_EN)
// master = cache datapath / refill path / Mem arbiter; slave = the buffer.
interface cache_writeback_buffer_if;
    import cache_wb_pkg::*;

    logic                 push;
    logic [LINE_AW-1:0]   push_addr;
    logic [LINE_W-1:0]    push_data;
    logic                 full;
    logic                 empty;
    logic                 mem_busy;
    logic                 CS;
    logic                 RW;
    logic [WADDR_W-1:0]   waddr;
    logic [WORD_W-1:0]    wdata;
    logic [LINE_AW-1:0]   lookup_addr;
    logic                 lookup_match;
`ifdef WB_FORWARD_EN
    logic [LINE_W-1:0]    lookup_data;
`endif

    modport master (
        output push, push_addr, push_data, mem_busy, lookup_addr,
`ifdef WB_FORWARD_EN
        input  lookup_data,
`endif
        input  full, empty, CS, RW, waddr, wdata, lookup_match
    );

    modport slave (
        input  push, push_addr, push_data, mem_busy, lookup_addr,
`ifdef WB_FORWARD_EN
        output lookup_data,
`endif
        output full, empty, CS, RW, waddr, wdata, lookup_match
    );

endinterface

// File: rtl/cache_wb_line_fifo.sv
// Line storage FIFO for the write-back buffer.
//   clk, reset  clock, synchronous active-high reset
//   i_push      enqueue i_line (ignored while o_full)
//   i_pop       dequeue head (ignored while o_empty)
//   o_full, o_empty, o_count  occupancy
//   o_head      oldest entry
//   o_valid/o_addrs[/o_datas]  entries in age order (index 0 = oldest)
// WB_FORWARD_EN: also exports per-entry data for lookup forwarding.
module cache_wb_line_fifo
    import cache_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_push,
    input  logic                                i_pop,
    input  wb_line_t                            i_line,
    output logic                                o_full,
    output logic                                o_empty,
    output logic [$clog2(DEPTH+1)-1:0]          o_count,
    output wb_line_t                            o_head,
    output logic [DEPTH-1:0]                    o_valid,
`ifdef WB_FORWARD_EN
    output logic [DEPTH-1:0][LINE_W-1:0]        o_datas,
`endif
    output logic [DEPTH-1:0][LINE_AW-1:0]       o_addrs
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_line_t       r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push_ok;
    logic           w_pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_line;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Rotate storage into age order so the lookup can pick the newest match
    // simply as the highest-indexed hit.
    always_comb begin
        int unsigned idx;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx        = (32'(r_rd_ptr) + k) % DEPTH;
            o_valid[k] = (k < 32'(r_count));
            o_addrs[k] = r_mem[idx[PW-1:0]].addr;
`ifdef WB_FORWARD_EN
            o_datas[k] = r_mem[idx[PW-1:0]].data;
`endif
        end
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer: queues evicted 128-bit lines and drains each into Mem
// as four 32-bit write beats, pausing while the refill path owns Mem.
//   clk, reset  clock, synchronous active-high reset
//   wb          cache_writeback_buffer_if.slave (push/full/empty,
//               mem_busy/CS/RW/waddr/wdata, lookup_addr/lookup_match)
// Optional macro WB_FORWARD_EN adds wb.lookup_data (newest matching line).
module cache_writeback_buffer
    import cache_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    cache_writeback_buffer_if.slave   wb
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_state_e                   r_state;
    wb_state_e                   w_state_nxt;
    logic [1:0]                  r_beat;
    logic [1:0]                  w_beat_nxt;
    logic                        w_pop;
    logic                        w_cs;
    logic                        w_match;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [CW-1:0]               w_count;
    wb_line_t                    w_head;
    wb_line_t                    w_push_line;
    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][LINE_AW-1:0] w_addrs;
`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0][LINE_W-1:0]  w_datas;
    logic [LINE_W-1:0]             w_fwd;
`endif

    assign w_push_line.addr = wb.push_addr;
    assign w_push_line.data = wb.push_data;

    cache_wb_line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (wb.push),
        .i_pop   (w_pop),
        .i_line  (w_push_line),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count),
        .o_head  (w_head),
        .o_valid (w_valid),
`ifdef WB_FORWARD_EN
        .o_datas (w_datas),
`endif
        .o_addrs (w_addrs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pop       = 1'b0;
        w_cs        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = WRITE;
                    w_beat_nxt  = '0;
                end
            end
            WRITE: begin
                if (!wb.mem_busy) begin
                    w_cs       = 1'b1;
                    w_beat_nxt = r_beat + 2'd1;   // wraps to 0 after beat 3
                    if (r_beat == 2'd3) begin
                        w_pop = 1'b1;
                        // Only the draining line is left: nothing to chain onto.
                        if (w_count == CW'(1)) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign wb.CS    = w_cs;
    assign wb.RW    = w_cs;
    assign wb.waddr = (r_state == WRITE) ? {w_head.addr, r_beat} : '0;
    assign wb.wdata = (r_state == WRITE) ? line_word(w_head.data, r_beat) : '0;
    assign wb.full  = w_fifo_full;
    assign wb.empty = w_fifo_empty && (r_state == IDLE);

    // The draining line stays in the FIFO until its beat 3 commits, so it is
    // covered by the valid vector like any other pending entry.
    always_comb begin
        w_match = 1'b0;
`ifdef WB_FORWARD_EN
        w_fwd   = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && (w_addrs[k] == wb.lookup_addr)) begin
                w_match = 1'b1;
`ifdef WB_FORWARD_EN
                w_fwd   = w_datas[k];   // age order: last hit is the newest
`endif
            end
        end
    end

    assign wb.lookup_match = w_match;
`ifdef WB_FORWARD_EN
    assign wb.lookup_data  = w_fwd;
`endif

endmodule

// File: tb/tb_cache_writeback_buffer.sv
module tb_cache_writeback_buffer;
    import cache_wb_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_writeback_buffer_if wb_if();

    cache_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending lines plus "which word of the head
    // line is next", advanced once per rising edge from the bench's own inputs.
    wb_line_t    mq[$];
    bit          m_active = 1'b0;
    int unsigned m_beat   = 0;

    always @(posedge clk) begin : ref_model
        int unsigned pre;
        wb_line_t    ln;
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_beat   = 0;
        end else begin
            pre = mq.size();
            if (m_active && !wb_if.mem_busy) begin
                if (m_beat == 3) begin
                    mq.delete(0);
                    m_beat   = 0;
                    m_active = (pre > 1);
                end else begin
                    m_beat++;
                end
            end else if (!m_active && pre != 0) begin
                m_active = 1'b1;
                m_beat   = 0;
            end
            if (wb_if.push && pre < DEPTH) begin
                ln.addr = wb_if.push_addr;
                ln.data = wb_if.push_data;
                mq.push_back(ln);
            end
        end
    end

    function automatic logic [42:0] model_vec();
        logic        match;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        cs;
        match = 1'b0;
        wa    = '0;
        wd    = '0;
        foreach (mq[i]) if (mq[i].addr == wb_if.lookup_addr) match = 1'b1;
        if (m_active) begin
            wa = {mq[0].addr, 2'(m_beat)};
            wd = mq[0].data[m_beat*32 +: 32];
        end
        cs = m_active && !wb_if.mem_busy;
        return {mq.size() == DEPTH, (mq.size() == 0) && !m_active, cs, cs, match, wa, wd};
    endfunction

    function automatic logic [42:0] dut_vec();
        return {wb_if.full, wb_if.empty, wb_if.CS, wb_if.RW, wb_if.lookup_match,
                wb_if.waddr, wb_if.wdata};
    endfunction

`ifdef WB_FORWARD_EN
    function automatic logic [LINE_W-1:0] model_fwd();
        logic [LINE_W-1:0] d;
        d = '0;
        foreach (mq[i]) if (mq[i].addr == wb_if.lookup_addr) d = mq[i].data;
        return d;
    endfunction
`endif

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        wb_if.push        = 1'b0;
        wb_if.push_addr   = '0;
        wb_if.push_data   = '0;
        wb_if.mem_busy    = 1'b0;
        wb_if.lookup_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (dut_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", dut_vec(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_line();
        logic [31:0] words [4];
        int unsigned k;
        words = '{32'd11, 32'd22, 32'd33, 32'd44};
        k = 0;
        @(negedge clk);
        wb_if.push        = 1'b1;
        wb_if.push_addr   = 4'h3;
        wb_if.push_data   = {words[3], words[2], words[1], words[0]};
        wb_if.lookup_addr = 4'h3;
        @(negedge clk);
        wb_if.push = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL single_model cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
            n_tests++;
            if (wb_if.lookup_match !== (k < 4)) begin
                n_fail++;
                $display("FAIL single_lookup cyc %0d: got %b required %b", cyc, wb_if.lookup_match, k < 4);
            end
`ifdef WB_FORWARD_EN
            n_tests++;
            if (wb_if.lookup_data !== ((k < 4) ? {words[3], words[2], words[1], words[0]} : 128'd0)) begin
                n_fail++;
                $display("FAIL single_fwd cyc %0d: got %h", cyc, wb_if.lookup_data);
            end
`endif
            if (wb_if.CS === 1'b1 && k < 4) begin
                n_tests++;
                if (wb_if.waddr !== 6'(12 + k) || wb_if.wdata !== words[k]) begin
                    n_fail++;
                    $display("FAIL single_beat %0d: got %0d/%0d required %0d/%0d", k,
                             wb_if.waddr, wb_if.wdata, 12 + k, words[k]);
                end
                k++;
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (k != 4 || wb_if.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done: beats %0d empty %b required 4 and 1", k, wb_if.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic       cs_log [24];
        logic [5:0] wa_log [24];
        int         first;
        first = -1;
        @(negedge clk);
        wb_if.push      = 1'b1;
        wb_if.push_addr = 4'h1;
        wb_if.push_data = rand_line();
        @(negedge clk);
        wb_if.push_addr = 4'h2;
        wb_if.push_data = rand_line();
        @(negedge clk);
        wb_if.push = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            #1;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b_model cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
            cs_log[cyc] = wb_if.CS;
            wa_log[cyc] = wb_if.waddr;
            if (first < 0 && wb_if.CS === 1'b1) first = cyc;
            @(negedge clk);
        end
        n_tests++;
        if (first < 0 || first > 14) begin
            n_fail++;
            $display("FAIL b2b_start: first CS cycle %0d required 0..14", first);
        end else begin
            for (int n = 0; n < 8; n++) begin
                n_tests++;
                if (cs_log[first+n] !== 1'b1 || wa_log[first+n] !== 6'(4 + n)) begin
                    n_fail++;
                    $display("FAIL b2b_beat %0d: got CS %b waddr %0d required 1 %0d", n,
                             cs_log[first+n], wa_log[first+n], 4 + n);
                end
            end
            n_tests++;
            if (cs_log[first+8] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_tail: got CS %b required 0", cs_log[first+8]);
            end
        end
    endtask

    task automatic test_full();
        int unsigned writes;
        writes = 0;
        @(negedge clk);
        wb_if.mem_busy  = 1'b1;
        wb_if.push      = 1'b1;
        wb_if.push_addr = 4'h6;
        wb_if.push_data = rand_line();
        @(negedge clk);
        wb_if.push_addr = 4'h7;
        wb_if.push_data = rand_line();
        @(negedge clk);
        #1;
        n_tests++;
        if (wb_if.full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_flag: got %b required 1", wb_if.full);
        end
        wb_if.push_addr = 4'h9;
        wb_if.push_data = rand_line();
        @(negedge clk);
        wb_if.push = 1'b0;
        #1;
        n_tests++;
        if (dut_vec() !== model_vec() || wb_if.full !== 1'b1 || wb_if.CS !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: got %h required %h", dut_vec(), model_vec());
        end
        @(negedge clk);
        wb_if.mem_busy = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL full_model cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
            if (wb_if.CS === 1'b1) begin
                writes++;
                n_tests++;
                if (wb_if.waddr[5:2] !== 4'h6 + 4'(writes > 4)) begin
                    n_fail++;
                    $display("FAIL full_order: got line %0d required %0d", wb_if.waddr[5:2],
                             (writes > 4) ? 7 : 6);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (writes != 8) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes required 8", writes);
        end
    endtask

    task automatic test_busy_pulse();
        int unsigned seen [$];
        int unsigned stall;
        bit          pulsed;
        stall  = 0;
        pulsed = 1'b0;
        @(negedge clk);
        wb_if.push      = 1'b1;
        wb_if.push_addr = 4'h5;
        wb_if.push_data = rand_line();
        @(negedge clk);
        wb_if.push = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (stall != 0) begin
                stall--;
                if (stall == 0) wb_if.mem_busy = 1'b0;
            end
            #1;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL busy_model cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
            if (stall != 0) begin
                n_tests++;
                if (wb_if.CS !== 1'b0 || wb_if.RW !== 1'b0 || wb_if.waddr !== 6'd21) begin
                    n_fail++;
                    $display("FAIL busy_stall: got CS %b RW %b waddr %0d required 0 0 21",
                             wb_if.CS, wb_if.RW, wb_if.waddr);
                end
            end
            if (!pulsed && wb_if.CS === 1'b1 && wb_if.waddr === 6'd21) begin
                pulsed         = 1'b1;
                wb_if.mem_busy = 1'b1;
                stall          = 3;
            end else if (wb_if.CS === 1'b1) begin
                seen.push_back(32'(wb_if.waddr));
            end
            @(negedge clk);
        end
        n_tests++;
        if (!pulsed || seen.size() != 4) begin
            n_fail++;
            $display("FAIL busy_writes: got %0d writes pulsed %b required 4 1", seen.size(), pulsed);
        end else begin
            foreach (seen[i]) begin
                n_tests++;
                if (seen[i] != 20 + i) begin
                    n_fail++;
                    $display("FAIL busy_addr %0d: got %0d required %0d", i, seen[i], 20 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        wb_if.push        = 1'b1;
        wb_if.push_addr   = 4'hA;
        wb_if.push_data   = rand_line();
        wb_if.lookup_addr = 4'hA;
        @(negedge clk);
        wb_if.push = 1'b0;
        for (int cyc = 0; cyc < 12 && !hit; cyc++) begin
            #1;
            if (wb_if.CS === 1'b1 && wb_if.waddr === 6'd42) begin
                hit   = 1'b1;
                reset = 1'b1;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (!hit || {wb_if.CS, wb_if.empty, wb_if.full, wb_if.lookup_match} !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_mid: hit %b got CS/empty/full/match %b required 0100", hit,
                     {wb_if.CS, wb_if.empty, wb_if.full, wb_if.lookup_match});
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (wb_if.CS !== 1'b0 || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL rst_quiet cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                wb_if.push        = 1'($urandom_range(0, 1));
                wb_if.push_addr   = 4'($urandom_range(0, 3));
                wb_if.push_data   = rand_line();
                wb_if.mem_busy    = ($urandom_range(0, 3) == 0);
                wb_if.lookup_addr = 4'($urandom_range(0, 3));
            end else begin
                wb_if.push     = 1'b0;
                wb_if.mem_busy = 1'b0;
            end
            #1;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL rand_model cyc %0d: got %h required %h", cyc, dut_vec(), model_vec());
            end
`ifdef WB_FORWARD_EN
            n_tests++;
            if (wb_if.lookup_data !== model_fwd()) begin
                n_fail++;
                $display("FAIL rand_fwd cyc %0d: got %h required %h", cyc, wb_if.lookup_data, model_fwd());
            end
`endif
        end
        n_tests++;
        if (wb_if.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_drain: got empty %b required 1", wb_if.empty);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_full();
        test_busy_pulse();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
